// File: rtl/snapshot_uploader_if.sv
// HPS upload port plus SDRAM read port of snapshot_uploader, bundled as one interface.
// The slave modport is the uploader; master is the surrounding hps_io / sdram mux side.
interface snapshot_uploader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [1:0]  bank_sel;
  logic        mem_rd;
  logic [22:0] mem_a;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_dout;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, bank_sel, mem_dout,
    input  ioctl_din, ioctl_wait, mem_rd, mem_a, mem_bank
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, bank_sel, mem_dout,
    output ioctl_din, ioctl_wait, mem_rd, mem_a, mem_bank
  );
endinterface

// File: rtl/snapshot_uploader.sv
// Serves HPS upload byte requests from SDRAM (one read per byte, ioctl_wait stretched).
// Optional SNAPSHOT_HEADER_EN prepends a 256-byte SNA v3 header to the RAM image.
module snapshot_uploader #(
  parameter logic [22:0] BASE   = 23'h000000,
  parameter int          LEN    = 131072,
  parameter int          RD_LAT = 2
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_ref,
  snapshot_uploader_if.slave  bus,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAITD, DONE} state_t;

`ifdef SNAPSHOT_HEADER_EN
  localparam int H = 256;
  localparam logic [15:0] LEN_KB = 16'(LEN / 1024);
`else
  localparam int H = 0;
`endif

  state_t      state, state_d;
  logic        upload_q;
  logic        upload_rise, upload_fall;
  logic        req_ok, rd_err;
  logic        is_hdr, is_oor;
  logic [24:0] off;
  logic [2:0]  cnt;
  logic        capture;

  assign upload_rise = bus.ioctl_upload & ~upload_q;
  assign upload_fall = ~bus.ioctl_upload & upload_q;

  // A request coincident with the upload rising edge is already part of the session.
  assign req_ok  = bus.ioctl_rd & (busy | upload_rise) & (state == IDLE) & ~upload_fall;
  assign rd_err  = bus.ioctl_rd & ~req_ok;
  assign off     = bus.ioctl_addr - 25'(H);
  assign is_oor  = (off >= 25'(LEN));
  assign capture = (state == WAITD) & ce_ref & (cnt == 3'd1) & ~upload_fall;

`ifdef SNAPSHOT_HEADER_EN
  assign is_hdr = (bus.ioctl_addr < 25'(H));

  function automatic logic [7:0] hdr_byte(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h4D;  // "MV - SNA"
      8'h01:   return 8'h56;
      8'h02:   return 8'h20;
      8'h03:   return 8'h2D;
      8'h04:   return 8'h20;
      8'h05:   return 8'h53;
      8'h06:   return 8'h4E;
      8'h07:   return 8'h41;
      8'h10:   return 8'h03;
      8'h6B:   return LEN_KB[7:0];
      8'h6C:   return LEN_KB[15:8];
      default: return 8'h00;
    endcase
  endfunction
`else
  assign is_hdr = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    case (state)
      IDLE:    if (req_ok && !is_hdr && !is_oor) state_d = ISSUE;
      ISSUE:   if (ce_ref) state_d = WAITD;
      WAITD:   if (ce_ref && cnt == 3'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (upload_fall) state_d = IDLE;
  end

  // Moore outputs straight off the state register, so they track it with no extra delay.
  always_comb begin
    bus.mem_rd     = (state == ISSUE);
    bus.ioctl_wait = (state != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_q      <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      bus.mem_bank  <= 2'd0;
      bus.mem_a     <= 23'd0;
      bus.ioctl_din <= 8'hFF;
      cnt           <= 3'd0;
    end else begin
      upload_q <= bus.ioctl_upload;

      if (upload_rise) begin
        busy         <= 1'b1;
        bus.mem_bank <= bus.bank_sel;
      end else if (upload_fall) begin
        busy <= 1'b0;
      end

      err <= (err & ~upload_rise) | rd_err;

      if (req_ok) begin
`ifdef SNAPSHOT_HEADER_EN
        if (is_hdr)      bus.ioctl_din <= hdr_byte(bus.ioctl_addr[7:0]);
        else if (is_oor) bus.ioctl_din <= 8'hFF;
        else             bus.mem_a     <= BASE + off[22:0];
`else
        if (is_oor)      bus.ioctl_din <= 8'hFF;
        else             bus.mem_a     <= BASE + off[22:0];
`endif
      end

      if (state == ISSUE && ce_ref)      cnt <= 3'(RD_LAT);
      else if (state == WAITD && ce_ref) cnt <= cnt - 3'd1;

      if (capture) bus.ioctl_din <= bus.mem_dout;
    end
  end

endmodule

// File: tb/tb_snapshot_uploader.sv
// Directed bench for snapshot_uploader with a small fixed-latency SDRAM model.
// Header checks are compiled in when SNAPSHOT_HEADER_EN is defined.
module tb_snapshot_uploader;

  localparam logic [22:0] BASE   = 23'h000000;
  localparam int          LEN    = 131072;
  localparam int          RD_LAT = 2;
`ifdef SNAPSHOT_HEADER_EN
  localparam int H = 256;
`else
  localparam int H = 0;
`endif

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ce_ref;
  logic busy, err;

  snapshot_uploader_if bus();

  snapshot_uploader #(.BASE(BASE), .LEN(LEN), .RD_LAT(RD_LAT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_ref  (ce_ref),
    .bus     (bus.slave),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk_sys = ~clk_sys;

  // ce_ref: one clk_sys pulse every fourth cycle
  logic [1:0] ce_div = 2'd0;
  int         ce_cnt = 0;
  always @(posedge clk_sys) begin
    ce_div <= ce_div + 2'd1;
    if (ce_ref) ce_cnt <= ce_cnt + 1;
  end
  assign ce_ref = (ce_div == 2'd3);

  // SDRAM model: data of the accepted address is valid only in the window sampled
  // on the RD_LAT-th ce_ref after acceptance; otherwise a poison value.
  function automatic logic [7:0] sdram_byte(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
  endfunction

  int          m_cnt = 0;
  logic [22:0] m_addr = 23'd0;
  int          rd_cycles = 0;
  always @(posedge clk_sys) begin
    if (bus.mem_rd) rd_cycles <= rd_cycles + 1;
    if (ce_ref) begin
      if (bus.mem_rd) begin
        m_cnt  <= RD_LAT;
        m_addr <= bus.mem_a;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign bus.mem_dout = (m_cnt == 1) ? sdram_byte(m_addr) : 8'hEE;

  int vectors    = 0;
  int miscompares = 0;
  bit to;
  int ce0, rc0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_rd(input logic [24:0] a);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!bus.ioctl_wait) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_accept(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!bus.mem_rd) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_din"},  32'(bus.ioctl_din),  32'hFF);
    check({tag, "_wait"}, 32'(bus.ioctl_wait), 32'h0);
    check({tag, "_mrd"},  32'(bus.mem_rd),     32'h0);
    check({tag, "_ma"},   32'(bus.mem_a),      32'h0);
    check({tag, "_bank"}, 32'(bus.mem_bank),   32'h0);
    check({tag, "_busy"}, 32'(busy),           32'h0);
    check({tag, "_err"},  32'(err),            32'h0);
  endtask

  initial begin
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 25'd0;
    bus.bank_sel     = 2'd0;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // upload start latches the bank
    bus.bank_sel     = 2'd1;
    bus.ioctl_upload = 1'b1;
    tick();
    check("start_busy", 32'(busy), 32'h1);
    check("start_bank", 32'(bus.mem_bank), 32'h1);

    // first RAM byte: wait/mem_rd on the decode edge, data after RD_LAT+1 ce_ref
    do_rd(25'(H));
    check("rd0_wait", 32'(bus.ioctl_wait), 32'h1);
    check("rd0_mrd",  32'(bus.mem_rd),     32'h1);
    check("rd0_ma",   32'(bus.mem_a),      32'h0);
    ce0 = ce_cnt;
    wait_idle(to);
    check("rd0_timeout", 32'(to), 32'h0);
    check("rd0_ce",      32'(ce_cnt - ce0), 32'd3);
    check("rd0_din",     32'(bus.ioctl_din), 32'h5A);
    check("rd0_mrd_off", 32'(bus.mem_rd), 32'h0);

    do_rd(25'(H + 32'h12345));
    wait_idle(to);
    check("rd1_timeout", 32'(to), 32'h0);
    check("rd1_ma",  32'(bus.mem_a),     32'h12345);
    check("rd1_din", 32'(bus.ioctl_din), 32'h3D);

    do_rd(25'(H + LEN - 1));
    wait_idle(to);
    check("rd2_timeout", 32'(to), 32'h0);
    check("rd2_ma",  32'(bus.mem_a),     32'h1FFFF);
    check("rd2_din", 32'(bus.ioctl_din), 32'h5B);

    // out of range: FF, no SDRAM access, no wait
    rc0 = rd_cycles;
    do_rd(25'(H + LEN));
    check("oor_din",  32'(bus.ioctl_din),  32'hFF);
    check("oor_wait", 32'(bus.ioctl_wait), 32'h0);
    tick(); tick();
    check("oor_nomrd", 32'(rd_cycles - rc0), 32'd0);
    do_rd(25'(H + 32'h0800000));
    check("oor_hi_wait", 32'(bus.ioctl_wait), 32'h0);
    tick();
    check("oor_hi_nomrd", 32'(rd_cycles - rc0), 32'd0);
    check("oor_err", 32'(err), 32'h0);

`ifdef SNAPSHOT_HEADER_EN
    begin
      logic [63:0] sig;
      sig = "MV - SNA";
      for (int i = 0; i < 8; i++) begin
        do_rd(25'(i));
        check("hdr_sig",  32'(bus.ioctl_din),  32'(sig[63 - 8*i -: 8]));
        check("hdr_wait", 32'(bus.ioctl_wait), 32'h0);
      end
      do_rd(25'h10);
      check("hdr_ver", 32'(bus.ioctl_din), 32'h03);
      do_rd(25'h6B);
      check("hdr_kb_lo", 32'(bus.ioctl_din), 32'h80);
      do_rd(25'h6C);
      check("hdr_kb_hi", 32'(bus.ioctl_din), 32'h00);
    end
`endif

    // request during WAITD: flagged, ignored, first read completes
    do_rd(25'(H + 32'h12345));
    wait_accept(to);
    check("err_acc_timeout", 32'(to), 32'h0);
    tick();
    do_rd(25'(H));
    check("err_set", 32'(err), 32'h1);
    wait_idle(to);
    check("err_timeout", 32'(to), 32'h0);
    check("err_din",    32'(bus.ioctl_din), 32'h3D);
    check("err_ma",     32'(bus.mem_a),     32'h12345);
    check("err_sticky", 32'(err), 32'h1);
    bus.ioctl_upload = 1'b0;
    tick();
    check("end_busy", 32'(busy), 32'h0);
    check("end_err",  32'(err),  32'h1);
    bus.ioctl_upload = 1'b1;
    tick();
    check("restart_err",  32'(err),  32'h0);
    check("restart_busy", 32'(busy), 32'h1);

    // drop upload while still in ISSUE
    to = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ce_ref) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    check("align_timeout", 32'(to), 32'h0);
    tick();
    do_rd(25'(H + 5));
    check("drop_mrd_pre", 32'(bus.mem_rd), 32'h1);
    bus.ioctl_upload = 1'b0;
    tick();
    check("drop_mrd",  32'(bus.mem_rd),     32'h0);
    check("drop_wait", 32'(bus.ioctl_wait), 32'h0);
    check("drop_busy", 32'(busy),           32'h0);

    // request outside a session
    do_rd(25'(H));
    check("idle_err",  32'(err),            32'h1);
    check("idle_wait", 32'(bus.ioctl_wait), 32'h0);
    tick();
    check("idle_mrd", 32'(bus.mem_rd), 32'h0);

    // upload start with coincident request, then reset during WAITD
    bus.bank_sel     = 2'd2;
    bus.ioctl_addr   = 25'(H + 32'h12345);
    bus.ioctl_rd     = 1'b1;
    bus.ioctl_upload = 1'b1;
    tick();
    bus.ioctl_rd     = 1'b0;
    check("co_busy", 32'(busy),           32'h1);
    check("co_bank", 32'(bus.mem_bank),   32'h2);
    check("co_wait", 32'(bus.ioctl_wait), 32'h1);
    check("co_err",  32'(err),            32'h0);
    wait_accept(to);
    check("co_acc_timeout", 32'(to), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    tick();
    check("post_busy", 32'(busy),         32'h1);
    check("post_bank", 32'(bus.mem_bank), 32'h2);
    do_rd(25'(H + LEN - 1));
    wait_idle(to);
    check("post_timeout", 32'(to), 32'h0);
    check("post_din", 32'(bus.ioctl_din), 32'h5B);
    check("post_err", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snapshot_uploader.md
Name: snapshot_uploader

Overview:
- Reader counterpart to the boot/expansion ROM loader: serves HPS upload requests (ioctl upload direction) by fetching bytes from SDRAM and returning them to the HPS.
- Used to save the CPC RAM image (64K/128K) to the SD card.
- Sits between hps_io's upload port and the sdram read mux; owns the SDRAM read port only while the core is held in reset/pause by the top level.
- Issues one SDRAM read per requested byte and stretches ioctl_wait until the data is valid.

Parameters:
- BASE, 23'h000000, SDRAM byte address mapped to RAM-image offset 0.
- LEN, 131072, RAM image length in bytes; must be a multiple of 1024, at most 2^22.
- RD_LAT, 2, number of ce_ref strobes from mem_rd acceptance to valid mem_dout (1..7).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_ref  in  1  SDRAM slot strobe, one clk_sys pulse per SDRAM cycle
- ioctl_upload  in  1  upload session active
- ioctl_rd  in  1  one-cycle byte request pulse
- ioctl_addr  in  25  requested byte offset within the uploaded file
- ioctl_din  out  8  byte returned to HPS
- ioctl_wait  out  1  high while the requested byte is not yet valid
- bank_sel  in  2  SDRAM bank to read; latched at upload start
- mem_rd  out  1  SDRAM read request
- mem_a  out  23  SDRAM byte address
- mem_bank  out  2  SDRAM bank
- mem_dout  in  8  SDRAM read data
- busy  out  1  high from upload start until the upload ends
- err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: single clock, clk_sys. Reset is synchronous, active-high.
- Reset values: ioctl_din=8'hFF, ioctl_wait=0, mem_rd=0, mem_a=0, mem_bank=0, busy=0, err=0, state=IDLE.
- Session control:
  - Rising edge of ioctl_upload latches bank_sel into mem_bank, clears err, and sets busy.
  - Falling edge of ioctl_upload clears busy and forces IDLE. Any in-flight read is abandoned: mem_rd=0, ioctl_wait=0.
- Request decode: only while busy and in IDLE. Let off = ioctl_addr minus H, where H=256 if SNAPSHOT_HEADER_EN is defined, else 0.
  - Header byte (ioctl_addr < H): ioctl_din is updated on the next clock. ioctl_wait stays 0. No SDRAM access.
  - Out of range (off >= LEN): ioctl_din=8'hFF on the next clock. ioctl_wait stays 0. No SDRAM access.
  - RAM byte: on the same clock, ioctl_wait=1, mem_a=BASE+off[22:0], mem_rd=1. Go to ISSUE.
- State machine:
  - IDLE: decode requests as above.
  - ISSUE: hold mem_rd=1 until a ce_ref is seen. That ce_ref counts as acceptance. On acceptance, mem_rd=0, load counter=RD_LAT, go to WAITD.
  - WAITD: decrement the counter on each ce_ref. On the ce_ref where the counter reaches 0, register ioctl_din=mem_dout, go to DONE.
  - DONE: ioctl_wait=0 on the next clock, return to IDLE.
- Latency:
  - Worst case, from ioctl_rd to ioctl_wait low, is (RD_LAT+1) ce_ref periods + 2 clk_sys.
  - ioctl_din stays stable until the next request completes.
- Error handling:
  - ioctl_rd while state != IDLE, or while busy=0: the request is ignored and err=1 (sticky until the next upload start or reset).
  - ioctl_rd coincident with the rising edge of ioctl_upload: treated as the first valid request.
- Address arithmetic:
  - off uses the full 25-bit compare.
  - mem_a wraps modulo 2^23; no saturation.
- Reset mid-operation: returns immediately to the reset values, including dropping ioctl_wait.

Optional Feature:
- Macro: SNAPSHOT_HEADER_EN
- Defined: the file starts with a 256-byte SNA v3 header, and the RAM image starts at file offset 256.
  - Bytes 0..7 = "MV - SNA" (ASCII).
  - Byte 0x10 = 8'h03.
  - Bytes 0x6B/0x6C = LEN/1024, little-endian.
  - All other header bytes = 0.
- Not defined: H=0. File offset 0 is RAM byte BASE, and no header logic is synthesised.

Test Plan:
- Start upload with bank_sel=1, then ioctl_rd with ioctl_addr=0 (header off), SDRAM[BASE]=8'h5A -> ioctl_wait rises on the same clock, mem_rd with mem_a=BASE and mem_bank=1, ioctl_din=8'h5A, ioctl_wait falls after RD_LAT+1 ce_ref.
- Header on: read addrs 0..7 -> "MV - SNA" with ioctl_wait never high. Addr 0x6B -> 8'h80 (LEN=131072). Addr 256 -> SDRAM[BASE].
- ioctl_addr=LEN (header off) -> ioctl_din=8'hFF, no mem_rd pulse, ioctl_wait stays 0.
- Second ioctl_rd during WAITD -> err=1, first request completes with correct data. err clears on the next ioctl_upload rising edge.
- Drop ioctl_upload during ISSUE -> mem_rd=0 and ioctl_wait=0 on the next clock, busy=0.
- Assert reset during WAITD -> all outputs return to their reset values on the next clock. A subsequent upload works normally.
